// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   General-purpose register file with a per-register busy scoreboard.
//   Register 0 is hard-wired to zero and can never be marked busy.
//   Reads are combinational and bypass a same-cycle write-back, so decode
//   sees the freshest value and a cleared busy bit without an extra cycle.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   ra_addr/ra_data/ra_busy   read port A (combinational)
//   rb_addr/rb_data/rb_busy   read port B (combinational)
//   wr_en/wr_addr/wr_data     write-back port (clears busy)
//   issue_en/issue_addr       decode issue port (sets busy)
//   issue_busy                busy state of issue_addr, with write-back bypass
//   busy_vec                  registered busy bits, bit i = register i
//   waw_err                   sticky flag: issue onto an already-busy register

// Single write-enabled register element used for each architectural register.
module reg_file_scoreboard_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the stored value unless the write strobe for this entry is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

module reg_file_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    ra_addr,
  output logic [WIDTH-1:0]     ra_data,
  output logic                 ra_busy,
  input  logic [ADDR_W-1:0]    rb_addr,
  output logic [WIDTH-1:0]     rb_data,
  output logic                 rb_busy,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic                 issue_busy,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic                 waw_err
);

  localparam int NREG = 2**ADDR_W;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;
  logic             wr_valid;
  logic             issue_valid;

  // Address 0 is a sink: writes and issues to it have no effect anywhere.
  assign wr_valid    = wr_en && (wr_addr != '0);
  assign issue_valid = issue_en && (issue_addr != '0);

  assign regs[0] = '0;

  genvar i;
  generate
    for (i = 1; i < NREG; i++) begin : g_entry
      reg_file_scoreboard_entry #(.WIDTH(WIDTH)) u_entry (
        .clk   (clk),
        .reset (reset),
        .en    (wr_valid && (wr_addr == ADDR_W'(i))),
        .d     (wr_data),
        .q     (regs[i])
      );
    end
  endgenerate

  // Scoreboard update. The issue assignment comes after the write-back
  // clear so a same-edge issue and write to one register leaves it busy:
  // the newly issued producer is still outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      if (wr_valid)
        busy[wr_addr] <= 1'b0;
      if (issue_valid)
        busy[issue_addr] <= 1'b1;
      if (issue_valid && issue_busy)
        waw_err <= 1'b1;
    end
  end

  assign busy_vec = busy;

  // Read ports and issue check bypass the write-back happening this cycle.
  // busy[0] is never set and regs[0] is zero, so address 0 needs no
  // special case here.
  always_comb begin
    ra_data    = regs[ra_addr];
    ra_busy    = busy[ra_addr];
    rb_data    = regs[rb_addr];
    rb_busy    = busy[rb_addr];
    issue_busy = busy[issue_addr];
    if (wr_valid && (wr_addr == ra_addr)) begin
      ra_data = wr_data;
      ra_busy = 1'b0;
    end
    if (wr_valid && (wr_addr == rb_addr)) begin
      rb_data = wr_data;
      rb_busy = 1'b0;
    end
    if (wr_valid && (wr_addr == issue_addr))
      issue_busy = 1'b0;
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard
//   Directed bench for reg_file_scoreboard. Inputs change 1 ns after a
//   rising edge; outputs are sampled 1 ns after inputs settle, well clear
//   of the next rising edge.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  ra_addr;
  logic [31:0] ra_data;
  logic        ra_busy;
  logic [4:0]  rb_addr;
  logic [31:0] rb_data;
  logic        rb_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        issue_busy;
  logic [31:0] busy_vec;
  logic        waw_err;

  int total = 0;
  int bad   = 0;

  reg_file_scoreboard #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .ra_addr    (ra_addr),
    .ra_data    (ra_data),
    .ra_busy    (ra_busy),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .rb_busy    (rb_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_busy (issue_busy),
    .busy_vec   (busy_vec),
    .waw_err    (waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let one rising edge commit the current inputs, then drop the strobes.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    ra_addr    = '0;
    rb_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;

    // Reset state
    #2;
    check_output("rst_busy_vec", busy_vec, 32'h0);
    check_output("rst_waw_err", {31'b0, waw_err}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i);
      rb_addr = 5'(31 - i);
      #1;
      check_output($sformatf("rst_ra_data[%0d]", i), ra_data, 32'h0);
      check_output($sformatf("rst_rb_data[%0d]", 31 - i), rb_data, 32'h0);
      check_output($sformatf("rst_ra_busy[%0d]", i), {31'b0, ra_busy}, 32'h0);
    end
    apply_stimulus();

    // Plain write to r5, read on both ports
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    apply_stimulus();
    ra_addr = 5'd5; rb_addr = 5'd5;
    #1;
    check_output("r5_ra_data", ra_data, 32'hDEADBEEF);
    check_output("r5_rb_data", rb_data, 32'hDEADBEEF);

    // Write to r0 is ignored, including by the bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    ra_addr = 5'd0;
    #1;
    check_output("r0_bypass", ra_data, 32'h0);
    apply_stimulus();
    #1;
    check_output("r0_stored", ra_data, 32'h0);

    // Issue to r0 never sets busy
    issue_en = 1'b1; issue_addr = 5'd0;
    #1;
    check_output("r0_issue_busy", {31'b0, issue_busy}, 32'h0);
    apply_stimulus();
    check_output("r0_busy_vec", busy_vec, 32'h0);

    // Issue r7, then write-back with same-cycle bypass
    issue_en = 1'b1; issue_addr = 5'd7;
    #1;
    check_output("r7_issue_busy_pre", {31'b0, issue_busy}, 32'h0);
    apply_stimulus();
    ra_addr = 5'd7;
    #1;
    check_output("r7_ra_busy", {31'b0, ra_busy}, 32'h1);
    check_output("r7_busy_vec", busy_vec, 32'h0000_0080);
    check_output("r7_issue_busy", {31'b0, issue_busy}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rb_addr = 5'd7;
    #1;
    check_output("r7_bypass_ra_data", ra_data, 32'hA5A5A5A5);
    check_output("r7_bypass_ra_busy", {31'b0, ra_busy}, 32'h0);
    check_output("r7_bypass_rb_data", rb_data, 32'hA5A5A5A5);
    check_output("r7_bypass_rb_busy", {31'b0, rb_busy}, 32'h0);
    check_output("r7_bypass_issue_busy", {31'b0, issue_busy}, 32'h0);
    check_output("r7_busy_vec_held", busy_vec, 32'h0000_0080);
    apply_stimulus();
    check_output("r7_busy_vec_clear", busy_vec, 32'h0);
    check_output("r7_stored", ra_data, 32'hA5A5A5A5);

    // Same-edge issue and write to r9: data lands, busy stays set
    issue_en = 1'b1; issue_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    apply_stimulus();
    ra_addr = 5'd9; rb_addr = 5'd9;
    #1;
    check_output("r9_ra_data", ra_data, 32'h1);
    check_output("r9_rb_busy", {31'b0, rb_busy}, 32'h1);
    check_output("r9_busy_vec", busy_vec, 32'h0000_0200);
    check_output("r9_waw_err", {31'b0, waw_err}, 32'h0);

    // Double issue to r3 raises a sticky WAW error
    issue_en = 1'b1; issue_addr = 5'd3;
    apply_stimulus();
    issue_en = 1'b1; issue_addr = 5'd3;
    #1;
    check_output("r3_issue_busy", {31'b0, issue_busy}, 32'h1);
    check_output("r3_waw_pre", {31'b0, waw_err}, 32'h0);
    apply_stimulus();
    check_output("r3_waw_post", {31'b0, waw_err}, 32'h1);
    check_output("r3_busy_vec", busy_vec, 32'h0000_0208);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0;
    apply_stimulus();
    apply_stimulus();
    check_output("r3_waw_sticky", {31'b0, waw_err}, 32'h1);
    check_output("r3_busy_vec_clear", busy_vec, 32'h0000_0200);

    // Write and issue r4, then reset between edges
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 5'd4;
    apply_stimulus();
    ra_addr = 5'd4;
    #1;
    check_output("r4_ra_data", ra_data, 32'hFFFFFFFF);
    check_output("r4_busy_vec", busy_vec, 32'h0000_0210);
    #1;
    reset = 1'b1;
    #1;
    check_output("rst_async_ra_data", ra_data, 32'h0);
    check_output("rst_async_busy_vec", busy_vec, 32'h0);
    check_output("rst_async_waw_err", {31'b0, waw_err}, 32'h0);
    // Write and issue presented across an edge while reset is held
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55555555;
    issue_en = 1'b1; issue_addr = 5'd4;
    apply_stimulus();
    reset = 1'b0;
    #1;
    check_output("rst_release_r4", ra_data, 32'h0);
    check_output("rst_release_busy_vec", busy_vec, 32'h0);

    // First edge after reset release operates normally
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h0BADF00D;
    issue_en = 1'b1; issue_addr = 5'd12;
    apply_stimulus();
    ra_addr = 5'd6; rb_addr = 5'd4;
    #1;
    check_output("post_rst_r6", ra_data, 32'h0BADF00D);
    check_output("post_rst_r4", rb_data, 32'h0);
    check_output("post_rst_busy_vec", busy_vec, 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
